// File: rtl/mcu_io_pkg.sv
// rtl/mcu_io_pkg.sv - shared TX state encoding and UART framing constants
// Purpose: types and constants shared by the MCU output-port UART blocks.
// Ports: none (package).
package mcu_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/mcu_io_fifo.sv
// rtl/mcu_io_fifo.sv - synchronous FIFO with same-edge read/write
// Purpose: small byte queue between the change detector and the TX FSM.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   wr_en, wr_data   push request and data; accepted when not full or when a
//                    pop happens on the same edge
//   rd_en            pop request; ignored while empty
//   rd_data          head entry (valid while not empty)
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
module mcu_io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_rd;
   logic             do_wr;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_rd   = rd_en && !empty;
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mcu_io_uart_tx.sv
// rtl/mcu_io_uart_tx.sv - MCU output-port change detector feeding a UART 8N1 transmitter
// Purpose: every change of io_output is queued and sent LSB first as an 8N1 frame.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   io_output    MCU output port; a value change is the write event
//   tx           registered serial line, idle high
//   busy         frame in progress or bytes queued
//   fifo_count   queue occupancy
//   overflow     sticky flag: a change was dropped because the queue was full
module mcu_io_uart_tx
   import mcu_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    io_output,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic [7:0]           last_q;
   logic                 change;
   logic                 overflow_q;

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic                 tx_q, tx_d;
   logic                 baud_done;

   logic                 fifo_rd_en;
   logic [DATA_BITS-1:0] fifo_rd_data;
   logic                 fifo_full;
   logic                 fifo_empty;

   // The MCU has no strobe: any difference from the shadow copy is a write.
   assign change = (io_output != last_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q     <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         last_q <= io_output;
         if (change && fifo_full && !fifo_rd_en) begin
            overflow_q <= 1'b1;
         end
      end
   end

   mcu_io_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (change),
      .rd_en   (fifo_rd_en),
      .wr_data (io_output),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      baud_d     = baud_q;
      fifo_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            // Pop only on registered non-empty, so a same-edge write into an
            // empty queue is never bypassed straight to the shifter.
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               shift_d    = fifo_rd_data;
               bit_cnt_d  = '0;
               baud_d     = '0;
               state_d    = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d    = '0;
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = STOP;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered, so tx changes on the
      // same edge as the state and never looks at the FIFO output directly.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         baud_q    <= '0;
         tx_q      <= IDLE_LEVEL;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         baud_q    <= baud_d;
         tx_q      <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign busy     = (state_q != IDLE) || (fifo_count != '0);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_mcu_io_uart_tx.sv
// tb/tb_mcu_io_uart_tx.sv - self-checking bench for mcu_io_uart_tx
module tb_mcu_io_uart_tx;

   localparam int C     = 4;
   localparam int D     = 4;
   localparam int FRAME = 10 * C;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] io_output;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   always #5 clk = ~clk;

   mcu_io_uart_tx #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .io_output  (io_output),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
         end
      end
   endfunction

   // Reference model: a queue of pending bytes plus a countdown of the
   // remaining line time of the frame being sent.
   logic [7:0] mq[$];
   int         timer  = 0;
   logic [7:0] m_last = 8'h00;
   logic [7:0] cur    = 8'h00;
   bit         m_ovf  = 1'b0;
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      int sz;
      bit pop;
      if (reset) begin
         mq.delete();
         timer  = 0;
         m_last = 8'h00;
         m_ovf  = 1'b0;
      end else begin
         sz  = mq.size();
         pop = (timer == 0) && (sz > 0);
         if (pop) cur = mq.pop_front();
         if (io_output != m_last) begin
            m_last = io_output;
            if (sz < D || pop) mq.push_back(io_output);
            else m_ovf = 1'b1;
         end
         if (pop) timer = FRAME;
         else if (timer > 0) timer--;
      end
   end

   function automatic logic exp_tx();
      int idx;
      if (timer == 0) return 1'b1;
      idx = (FRAME - timer) / C;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return cur[idx-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_tx", 32'(tx), 32'(exp_tx()));
         check("cyc_busy", 32'(busy), 32'((timer != 0) || (mq.size() != 0)));
         check("cyc_fifo_count", 32'(fifo_count), 32'(mq.size()));
         check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // UART receiver sampling mid-bit. since_fall < 0 means wait for the start
   // edge; otherwise the caller is already that many cycles into the frame.
   task automatic get_frame(output logic [7:0] data, output bit ok,
                            input int budget, input int since_fall);
      int t;
      int w;
      ok   = 1'b1;
      data = 8'h00;
      t    = 0;
      if (since_fall < 0) begin
         w = 0;
         while (tx !== 1'b0 && w < budget) begin
            @(negedge clk);
            w++;
         end
         if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
         end
      end else begin
         t = since_fall;
      end
      for (int k = 0; k < 10; k++) begin
         int target;
         target = k * C + C / 2;
         if (t > target) continue;
         while (t < target) begin
            @(negedge clk);
            t++;
         end
         if (k == 0) begin
            if (tx !== 1'b0) ok = 1'b0;
         end else if (k == 9) begin
            if (tx !== 1'b1) ok = 1'b0;
         end else begin
            data[k-1] = tx;
         end
      end
   endtask

   task automatic expect_frame(input logic [7:0] exp, input string name,
                               input int budget, input int since_fall);
      logic [7:0] data;
      bit         ok;
      get_frame(data, ok, budget, since_fall);
      check(name, 32'(data), 32'(exp));
      check({name, "_framing"}, 32'(ok), 32'd1);
   endtask

   task automatic expect_quiet(input int cycles, input string name);
      int lows;
      lows = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check(name, 32'(lows), 32'd0);
   endtask

   typedef struct {
      logic [7:0] val;
      int         cnt;
      bit         ovf;
   } vec_t;

   vec_t burst[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      burst[0] = '{8'h01, 1, 1'b0};
      burst[1] = '{8'h02, 1, 1'b0};
      burst[2] = '{8'h03, 2, 1'b0};
      burst[3] = '{8'h04, 3, 1'b0};
      burst[4] = '{8'h05, 4, 1'b0};
      burst[5] = '{8'h06, 4, 1'b1};

      // Reset values
      reset     = 1'b1;
      io_output = 8'h00;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_fifo_count", 32'(fifo_count), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      expect_quiet(100, "idle_no_frame");

      // Single byte with latency and busy window
      io_output = 8'hA5;
      @(negedge clk);
      check("lat_e0_tx", 32'(tx), 32'd1);
      check("lat_e0_count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      check("lat_e1_tx_fall", 32'(tx), 32'd0);
      expect_frame(8'hA5, "single_a5", 1, 0);
      @(negedge clk);
      check("single_busy_f39", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      check("single_busy_f41", 32'(busy), 32'd0);

      // Held value gives one frame
      io_output = 8'h3C;
      expect_frame(8'h3C, "hold_3c", 10, -1);
      expect_quiet(150, "hold_no_repeat");

      // Returning to an earlier value is a change
      io_output = 8'h00;
      expect_frame(8'h00, "repeat_00", 10, -1);
      io_output = 8'h3C;
      expect_frame(8'h3C, "repeat_3c", 20, -1);
      repeat (10) @(negedge clk);

      // Burst: one change per cycle, sixth is dropped
      for (int i = 0; i < 6; i++) begin
         io_output = burst[i].val;
         @(negedge clk);
         check($sformatf("burst_count_%0d", i), 32'(fifo_count), 32'(burst[i].cnt));
         check($sformatf("burst_ovf_%0d", i), 32'(overflow), 32'(burst[i].ovf));
      end
      expect_frame(8'h01, "burst_01", 1, 4);
      expect_frame(8'h02, "burst_02", 10, -1);
      expect_frame(8'h03, "burst_03", 10, -1);
      expect_frame(8'h04, "burst_04", 10, -1);
      expect_frame(8'h05, "burst_05", 10, -1);
      expect_quiet(60, "burst_no_06");
      check("burst_ovf_sticky", 32'(overflow), 32'd1);

      // Reset mid-frame with two bytes queued
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      io_output = 8'hFF;
      @(negedge clk);
      io_output = 8'h11;
      @(negedge clk);
      io_output = 8'h22;
      @(negedge clk);
      repeat (16) @(negedge clk);
      check("mid_count", 32'(fifo_count), 32'd2);
      reset     = 1'b1;
      io_output = 8'h00;
      @(negedge clk);
      check("mid_reset_tx", 32'(tx), 32'd1);
      check("mid_reset_count", 32'(fifo_count), 32'd0);
      check("mid_reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      expect_quiet(100, "mid_no_resume");

      // OUT sequence as produced by the MCU core: 11 then 22
      io_output = 8'h11;
      repeat (2) @(negedge clk);
      repeat (6) @(negedge clk);
      io_output = 8'h22;
      expect_frame(8'h11, "mcu_11", 1, 6);
      expect_frame(8'h22, "mcu_22", 10, -1);
      repeat (10) @(negedge clk);

      // Random change pattern against the model, one reset in the middle
      for (int n = 0; n < 40; n++) begin
         io_output = 8'($urandom_range(0, 255));
         repeat ($urandom_range(1, 80)) @(negedge clk);
         if (n == 20) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      repeat (FRAME * 6) @(negedge clk);
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_tx", 32'(tx), 32'd1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
